// File: rtl/shifter_pkg.sv
// Shared definitions for pipelined_shifter: operation codes and layer-to-stage mapping.
package shifter_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Pipeline stage that owns mux layer `layer` out of `shw` layers.
  function automatic int unsigned layer_stage(input int unsigned layer,
                                              input int unsigned stages,
                                              input int unsigned shw);
    return (layer * stages) / shw;
  endfunction

  // Highest-numbered layer owned by `stage`; its output feeds that stage's register bank.
  function automatic int unsigned stage_last_layer(input int unsigned stage,
                                                   input int unsigned stages,
                                                   input int unsigned shw);
    int unsigned last;
    last = 0;
    for (int unsigned k = 0; k < shw; k++) begin
      if (layer_stage(k, stages, shw) == stage) last = k;
    end
    return last;
  endfunction

endpackage

// File: rtl/shift_layer.sv
// One combinational mux layer of the barrel shifter: shifts/rotates by AMT when en is set.
module shift_layer
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT   = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  input  logic             en,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);

  // Upper AMT bits set: the positions an arithmetic right shift must fill with sign.
  localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> AMT);

  // Select the shifted/rotated word for this layer; pass-through ops and en=0 leave data alone.
  always_comb begin
    result = data;
    if (en) begin
      case (op)
        OP_SLL:  result = data << AMT;
        OP_SRL:  result = data >> AMT;
        OP_SRA:  result = (data >> AMT) | (sign ? FILL_MASK : '0);
        OP_ROL:  result = (data << AMT) | (data >> (WIDTH - AMT));
        OP_ROR:  result = (data >> AMT) | (data << (WIDTH - AMT));
        default: result = data;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter/rotator with valid/ready handshake and a sideband tag.
// Optional flag outputs (out_zero, out_carry) are built when PIPELINED_SHIFTER_FLAGS_EN is defined.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [2:0]               in_op,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
`ifdef PIPELINED_SHIFTER_FLAGS_EN
  ,
  output logic                     out_zero,
  output logic                     out_carry
`endif
);

  localparam int unsigned SHW = $clog2(WIDTH);

  // Register banks, one entry per stage; entry STAGES-1 drives the outputs.
  logic [STAGES-1:0]             stg_valid;
  logic [STAGES-1:0][WIDTH-1:0]  stg_data;
  logic [STAGES-1:0][2:0]        stg_op;
  logic [STAGES-1:0][SHW-1:0]    stg_shamt;
  logic [STAGES-1:0]             stg_sign;
  logic [STAGES-1:0][TAG_W-1:0]  stg_tag;

  // Values each stage loads on advance: its upstream controls and its last layer's output.
  logic [STAGES-1:0]             src_valid;
  logic [STAGES-1:0][2:0]        src_op;
  logic [STAGES-1:0][SHW-1:0]    src_shamt;
  logic [STAGES-1:0]             src_sign;
  logic [STAGES-1:0][TAG_W-1:0]  src_tag;
  logic [STAGES-1:0][WIDTH-1:0]  stage_d;

  logic adv;

  // Whole pipe moves together whenever the output slot is free or being drained.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = stg_valid[STAGES-1];
  assign out_data  = stg_data[STAGES-1];
  assign out_tag   = stg_tag[STAGES-1];

  // Mux layers; a layer takes the previous layer's output, or the register bank at a stage boundary.
  for (genvar k = 0; k < SHW; k++) begin : g_layer
    localparam int unsigned S = layer_stage(k, STAGES, SHW);
    logic [WIDTH-1:0] layer_in;
    logic [WIDTH-1:0] layer_out;

    if (k == 0) begin : g_first
      assign layer_in = in_data;
    end else if (layer_stage(k - 1, STAGES, SHW) != S) begin : g_boundary
      assign layer_in = stg_data[S-1];
    end else begin : g_chain
      assign layer_in = g_layer[k-1].layer_out;
    end

    shift_layer #(
      .WIDTH (WIDTH),
      .AMT   (2 ** k)
    ) u_layer (
      .data   (layer_in),
      .op     (src_op[S]),
      .en     (src_shamt[S][k]),
      .sign   (src_sign[S]),
      .result (layer_out)
    );
  end

`ifdef PIPELINED_SHIFTER_FLAGS_EN
  logic [STAGES-1:0] stg_carry;
  logic [STAGES-1:0] src_carry;
  logic              zero_q;
  logic              carry_c;
  logic [SHW-1:0]    neg_shamt;
  logic [SHW-1:0]    shamt_m1;

  assign neg_shamt = -in_shamt;
  assign shamt_m1  = in_shamt - SHW'(1);
  assign out_zero  = zero_q;
  assign out_carry = stg_carry[STAGES-1];

  // Last bit shifted out, taken from the original operand; rotates report the wrapped bit.
  always_comb begin
    carry_c = 1'b0;
    if (in_shamt != '0) begin
      case (in_op)
        OP_SLL, OP_ROL:         carry_c = in_data[neg_shamt];
        OP_SRL, OP_SRA, OP_ROR: carry_c = in_data[shamt_m1];
        default:                carry_c = 1'b0;
      endcase
    end
  end
`endif

  // Per-stage sources: stage 0 from the request port, later stages from the preceding bank.
  for (genvar s = 0; s < STAGES; s++) begin : g_src
    localparam int unsigned LAST = stage_last_layer(s, STAGES, SHW);
    assign stage_d[s] = g_layer[LAST].layer_out;

    if (s == 0) begin : g_head
      assign src_valid[s] = in_valid;
      assign src_op[s]    = in_op;
      assign src_shamt[s] = in_shamt;
      assign src_sign[s]  = in_data[WIDTH-1];
      assign src_tag[s]   = in_tag;
`ifdef PIPELINED_SHIFTER_FLAGS_EN
      assign src_carry[s] = carry_c;
`endif
    end else begin : g_body
      assign src_valid[s] = stg_valid[s-1];
      assign src_op[s]    = stg_op[s-1];
      assign src_shamt[s] = stg_shamt[s-1];
      assign src_sign[s]  = stg_sign[s-1];
      assign src_tag[s]   = stg_tag[s-1];
`ifdef PIPELINED_SHIFTER_FLAGS_EN
      assign src_carry[s] = stg_carry[s-1];
`endif
    end
  end

  // Pipeline register banks: all stages load together on advance, hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_valid <= '0;
      stg_data  <= '0;
      stg_op    <= '0;
      stg_shamt <= '0;
      stg_sign  <= '0;
      stg_tag   <= '0;
`ifdef PIPELINED_SHIFTER_FLAGS_EN
      stg_carry <= '0;
      zero_q    <= 1'b0;
`endif
    end else if (adv) begin
      stg_valid <= src_valid;
      stg_data  <= stage_d;
      stg_op    <= src_op;
      stg_shamt <= src_shamt;
      stg_sign  <= src_sign;
      stg_tag   <= src_tag;
`ifdef PIPELINED_SHIFTER_FLAGS_EN
      stg_carry <= src_carry;
      zero_q    <= (stage_d[STAGES-1] == '0);
`endif
    end
  end

  // Control travelling past the final layer has no consumer.
  logic unused_ctrl;
  assign unused_ctrl = ^{stg_op, stg_shamt, stg_sign};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: vector table across STAGES=1/2/5,
// stall/order sequence, mid-flight reset and a randomized stream against a reference model.
module tb_pipelined_shifter;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [2:0]  in_op;
  logic [4:0]  in_shamt;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        ir1, ir2, ir5;
  logic        ov1, ov2, ov5;
  logic [31:0] od1, od2, od5;
  logic [4:0]  ot1, ot2, ot5;
`ifdef PIPELINED_SHIFTER_FLAGS_EN
  logic        oz1, oz2, oz5;
  logic        oc1, oc2, oc5;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [4:0]  tag;
    logic [31:0] exp;
    logic        exp_zero;
    logic        exp_carry;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
    logic        z;
    logic        c;
  } exp_t;

  vec_t vecs[11];
  exp_t q[$];

  pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .in_op(in_op), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_tag(ot2)
`ifdef PIPELINED_SHIFTER_FLAGS_EN
    , .out_zero(oz2), .out_carry(oc2)
`endif
  );

  pipelined_shifter #(.WIDTH(32), .STAGES(1), .TAG_W(5)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .in_op(in_op), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_tag(ot1)
`ifdef PIPELINED_SHIFTER_FLAGS_EN
    , .out_zero(oz1), .out_carry(oc1)
`endif
  );

  pipelined_shifter #(.WIDTH(32), .STAGES(5), .TAG_W(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir5),
    .in_data(in_data), .in_op(in_op), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(ov5), .out_ready(out_ready), .out_data(od5), .out_tag(ot5)
`ifdef PIPELINED_SHIFTER_FLAGS_EN
    , .out_zero(oz5), .out_carry(oc5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: {carry, zero, result} from plain wide arithmetic on the operand.
  function automatic logic [33:0] ref_model(input logic [2:0] op, input logic [31:0] d,
                                            input logic [4:0] sh);
    logic [63:0] w;
    logic [31:0] r;
    logic        c;
    r = d;
    c = 1'b0;
    case (op)
      3'd0: begin w = {32'd0, d} << sh; r = w[31:0];  c = w[32]; end
      3'd1: begin w = {d, 32'd0} >> sh; r = w[63:32]; c = w[31]; end
      3'd2: begin w = $signed({d, 32'd0}) >>> sh; r = w[63:32]; c = w[31]; end
      3'd3: begin w = {d, d} << sh; r = w[63:32]; c = (sh != 0) && r[0]; end
      3'd4: begin w = {d, d} >> sh; r = w[31:0];  c = (sh != 0) && r[31]; end
      default: begin r = d; c = 1'b0; end
    endcase
    return {c, (r == 32'd0), r};
  endfunction

  // One isolated request; latency, data and tag checked on all three pipeline depths.
  task automatic send_one(input vec_t v, input string nm);
    int lat1 = 0, lat2 = 0, lat5 = 0;
    logic [31:0] d1, d2, d5;
    logic [4:0]  t1, t2, t5;
    logic        z2, c2;
    @(negedge clk);
    in_valid = 1'b1; in_op = v.op; in_data = v.data; in_shamt = v.shamt; in_tag = v.tag;
    out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, ir2, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (ov1 && lat1 == 0) begin lat1 = c; d1 = od1; t1 = ot1; end
      if (ov5 && lat5 == 0) begin lat5 = c; d5 = od5; t5 = ot5; end
      if (ov2 && lat2 == 0) begin
        lat2 = c; d2 = od2; t2 = ot2;
`ifdef PIPELINED_SHIFTER_FLAGS_EN
        z2 = oz2; c2 = oc2;
`endif
      end
      @(negedge clk);
    end
    chk({nm, "_lat_s1"}, lat1, 1);
    chk({nm, "_lat_s2"}, lat2, 2);
    chk({nm, "_lat_s5"}, lat5, 5);
    chk({nm, "_data_s1"}, d1, v.exp);
    chk({nm, "_data_s2"}, d2, v.exp);
    chk({nm, "_data_s5"}, d5, v.exp);
    chk({nm, "_tag_s1"}, t1, v.tag);
    chk({nm, "_tag_s2"}, t2, v.tag);
    chk({nm, "_tag_s5"}, t5, v.tag);
`ifdef PIPELINED_SHIFTER_FLAGS_EN
    chk({nm, "_zero"}, z2, v.exp_zero);
    chk({nm, "_carry"}, c2, v.exp_carry);
`else
    z2 = 1'b0; c2 = 1'b0;
`endif
  endtask

  // Streamed requests on the STAGES=2 instance with a scoreboard queue.
  // rnd=0: four fixed ops back-to-back, out_ready low for cycles 3..5. rnd=1: random traffic.
  task automatic run_stream(input int n, input bit rnd, input string nm);
    int sent = 0, got = 0, cyc = 0, extra = 0;
    bit have = 1'b0, held = 1'b0;
    logic [31:0] hd;
    logic [4:0]  ht;
    logic [2:0]  cop;
    logic [31:0] cdat;
    logic [4:0]  csh, ctag;
    logic [33:0] m;
    exp_t e;
    logic [2:0]  s_op[4];
    logic [31:0] s_dat[4];
    logic [4:0]  s_sh[4];
    s_op[0] = 3'd0; s_dat[0] = 32'h0000_0001; s_sh[0] = 5'd4;
    s_op[1] = 3'd4; s_dat[1] = 32'hF000_0000; s_sh[1] = 5'd4;
    s_op[2] = 3'd2; s_dat[2] = 32'h8000_0010; s_sh[2] = 5'd4;
    s_op[3] = 3'd1; s_dat[3] = 32'hFFFF_FFFF; s_sh[3] = 5'd31;
    q.delete();
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      if (held) begin
        chk({nm, "_hold_valid"}, ov2, 1'b1);
        chk({nm, "_hold_data"}, od2, hd);
        chk({nm, "_hold_tag"}, ot2, ht);
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 3 && cyc < 6);
      if (!have && sent < n && (!rnd || $urandom_range(0, 4) != 0)) begin
        have = 1'b1;
        if (rnd) begin
          cop  = 3'($urandom_range(0, 7));
          cdat = $urandom;
          csh  = 5'($urandom_range(0, 31));
          ctag = 5'($urandom_range(0, 31));
        end else begin
          cop  = s_op[sent];
          cdat = s_dat[sent];
          csh  = s_sh[sent];
          ctag = 5'(sent + 1);
        end
      end
      in_valid = have; in_op = cop; in_data = cdat; in_shamt = csh; in_tag = ctag;
      #1;
      if (ov2 && !out_ready) chk({nm, "_stall_in_ready"}, ir2, 1'b0);
      if (ov2 && out_ready) begin
        chk({nm, "_result_expected"}, (q.size() != 0), 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk({nm, "_data"}, od2, e.d);
          chk({nm, "_tag"}, ot2, e.t);
`ifdef PIPELINED_SHIFTER_FLAGS_EN
          chk({nm, "_zero"}, oz2, e.z);
          chk({nm, "_carry"}, oc2, e.c);
`endif
        end
        got++;
      end
      held = ov2 && !out_ready;
      hd = od2;
      ht = ot2;
      if (in_valid && ir2) begin
        m = ref_model(cop, cdat, csh);
        e.d = m[31:0]; e.z = m[32]; e.c = m[33]; e.t = ctag;
        q.push_back(e);
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    chk({nm, "_delivered"}, got, n);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ov2) extra++;
    end
    chk({nm, "_no_duplicate"}, extra, 0);
  endtask

  initial begin
    int stale;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0; in_shamt = '0; in_tag = '0;
    out_ready = 1'b1;

    //            op    data           sh    tag    expected      z     c
    vecs[0]  = '{3'd2, 32'h8000_0000, 5'd31, 5'd5,  32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 32'h8000_0000, 5'd31, 5'd6,  32'h0000_0001, 1'b0, 1'b0};
    vecs[2]  = '{3'd4, 32'h1234_5678, 5'd8,  5'd7,  32'h7812_3456, 1'b0, 1'b0};
    vecs[3]  = '{3'd3, 32'h8000_0001, 5'd1,  5'd8,  32'h0000_0003, 1'b0, 1'b1};
    vecs[4]  = '{3'd0, 32'h0000_FFFF, 5'd16, 5'd9,  32'hFFFF_0000, 1'b0, 1'b0};
    vecs[5]  = '{3'd7, 32'hDEAD_BEEF, 5'd5,  5'd10, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[6]  = '{3'd0, 32'h1234_5678, 5'd0,  5'd11, 32'h1234_5678, 1'b0, 1'b0};
    vecs[7]  = '{3'd2, 32'h7FFF_FFFF, 5'd4,  5'd12, 32'h07FF_FFFF, 1'b0, 1'b1};
    vecs[8]  = '{3'd5, 32'hCAFE_F00D, 5'd3,  5'd13, 32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[9]  = '{3'd0, 32'h8000_0000, 5'd1,  5'd14, 32'h0000_0000, 1'b1, 1'b1};
    vecs[10] = '{3'd1, 32'h0000_0002, 5'd1,  5'd15, 32'h0000_0001, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_valid_s2", ov2, 1'b0);
    chk("reset_data_s2", od2, 32'd0);
    chk("reset_tag_s2", ot2, 5'd0);
    chk("reset_valid_s1", ov1, 1'b0);
    chk("reset_valid_s5", ov5, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) send_one(vecs[i], $sformatf("vec%0d", i));

    run_stream(4, 1'b0, "stall");

    // Two requests in flight, then an asynchronous reset pulse.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd0; in_data = 32'h0000_00F0; in_shamt = 5'd4; in_tag = 5'd21;
    @(negedge clk);
    in_op = 3'd1; in_data = 32'hF000_0000; in_shamt = 5'd8; in_tag = 5'd22;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_reset_valid", ov2, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_valid", ov2, 1'b0);
    chk("mid_reset_data", od2, 32'd0);
    chk("mid_reset_tag", ot2, 5'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov1 || ov2 || ov5) stale++;
    end
    chk("no_stale_after_reset", stale, 0);
    send_one(vecs[2], "post_reset");

    run_stream(300, 1'b1, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the combinational 32-bit shift unit.
- Generic WIDTH; configurable pipeline depth; adds rotate modes; valid/ready handshake in both directions; passes through a tag, for example a destination register ID.
- Sits between issue and writeback in the execute stage. Supports multi-cycle shifts at high clock rates.

Parameters:
- WIDTH, 32: data width. Must be a power of 2 and at least 2.
- STAGES, 2: number of pipeline register stages, range 1..$clog2(WIDTH). This is the latency in cycles.
- TAG_W, 5: width of the sideband tag carried alongside the data.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_data  in  WIDTH  operand.
- in_op  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others pass-through.
- in_shamt  in  $clog2(WIDTH)  shift amount.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the request that produced out_data.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All stage valid bits = 0, so out_valid = 0.
  - out_data = 0, out_tag = 0.
  - In-flight requests are discarded. No partial results after reset release.
- Datapath:
  - SHW = $clog2(WIDTH) mux layers. Layer k shifts/rotates by 2^k when shamt[k] = 1.
  - Layer k belongs to stage floor(k*STAGES/SHW). A register bank follows each stage.
  - Op, remaining shamt bits and tag travel with the data.
- Latency: exactly STAGES cycles from acceptance to out_valid when out_ready stays 1. Throughput: 1 request per cycle.
- Advance rule:
  - adv = !out_valid || out_ready.
  - in_ready = adv, combinationally.
  - When adv = 1, all stages shift forward together and stage 0 loads in_valid (and its data) on acceptance.
  - When adv = 0, every stage holds, and out_data/out_tag stay stable.
  - Internal bubbles do not collapse.
- Operations:
  - SLL: zero fill from the LSB end.
  - SRL: zero fill from the MSB end.
  - SRA: fill with original in_data[WIDTH-1], captured at acceptance and carried through the stages.
  - ROL/ROR: rotate, with no bits lost.
- Edge cases:
  - shamt = 0: out_data = in_data for all ops.
  - Ops 101/110/111: out_data = in_data, and the shamt field is ignored.
  - shamt = WIDTH-1 with SRA of a negative value: all ones.
- Simultaneous events:
  - Output handshake and input acceptance in the same cycle is legal.
  - The pipeline stays full with no lost or duplicated results.
- Ordering: results leave in strict acceptance order.

Optional Feature:
- Macro: PIPELINED_SHIFTER_FLAGS_EN.
- When defined, two outputs are added:
  - out_zero, 1 bit: 1 when out_data == 0.
  - out_carry, 1 bit:
    - SLL: bit in_data[WIDTH-shamt].
    - SRL/SRA: bit in_data[shamt-1].
    - ROL: result[0].
    - ROR: result[WIDTH-1].
    - 0 when shamt = 0 or for pass-through ops.
  - Both outputs are registered with out_data and reset to 0.
- When undefined, neither port exists and no flag logic is generated.

Decomposition:
- Package shifter_pkg holds:
  - the op localparams: OP_SLL = 3'b000, OP_SRL = 3'b001, OP_SRA = 3'b010, OP_ROL = 3'b011, OP_ROR = 3'b100;
  - a function that maps a layer index to its stage.
- Sub-module shift_layer: one combinational layer.
  - Parameters: WIDTH and AMT (= 2^k).
  - Inputs: data, op, enable bit, sign bit.
  - Output: data.
  - Generated SHW times inside pipelined_shifter.

Test Plan:
- WIDTH=32, STAGES=2: SRA 0x80000000 by 31 → 0xFFFFFFFF with tag preserved, out_valid exactly 2 cycles after acceptance. SRL of the same value by 31 → 0x00000001.
- ROR 0x12345678 by 8 → 0x78123456. ROL 0x80000001 by 1 → 0x00000003. SLL 0x0000FFFF by 16 → 0xFFFF0000.
- Back-to-back stream of 4 ops with out_ready held low 3 cycles mid-stream:
  - in_ready low while out_valid && !out_ready;
  - out_data/out_tag stable while held;
  - all 4 results delivered in order, none duplicated.
- reset_n pulsed low while 2 requests are in flight → out_valid = 0 immediately. After release, the next request completes normally and no stale result appears.
- Op 111 with shamt 5 on 0xDEADBEEF → 0xDEADBEEF. SLL by 0 → unchanged. Repeat with STAGES=1 and STAGES=5: latency 1 and 5 respectively.
- Flags build: SLL 0x80000000 by 1 → out_data 0, out_zero 1, out_carry 1. SRL 0x00000002 by 1 → out_carry 0, out_zero 0.
